rptr_wsync: RTL and testbench
=============================

RPTR_WSYNC -- requirements
Module: rptr_wsync

Interface
REQ-001 The block SHALL have parameter PTRWIDTH, default 3, meaning address width; DEPTH = 2**PTRWIDTH entries, and pointers are PTRWIDTH+1 bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the synchronizer chain, legal values 2..4.
REQ-003 The block SHALL have parameter AF_THRESH, default 1, meaning the almost-full margin in entries, legal values 1..DEPTH-1.
REQ-004 wclk  input  1  write-domain clock; all state is clocked on the rising edge.
REQ-005 wrst_n  input  1  asynchronous, active-low reset.
REQ-006 g_rptr  input  PTRWIDTH+1  Gray read pointer from the read domain; asynchronous to wclk.
REQ-007 b_wptr  input  PTRWIDTH+1  binary write pointer; wclk domain.
REQ-008 g_rptr_sync  output  PTRWIDTH+1  synchronized Gray read pointer.
REQ-009 b_rptr_sync  output  PTRWIDTH+1  binary equivalent of g_rptr_sync, registered.
REQ-010 wr_level  output  PTRWIDTH+1  occupied entries as seen from the write side, registered.
REQ-011 wr_free  output  PTRWIDTH+1  free entries, equal to DEPTH - wr_level, registered.
REQ-012 almost_full  output  1  asserted when wr_level >= DEPTH-AF_THRESH, registered.
REQ-013 rptr_adv  output  1  one-cycle pulse when the synchronized read pointer changes.
REQ-014 gray_err  output  1  sticky protocol-error flag; present only under the macro defined in REQ-027.

Function
REQ-015 g_rptr SHALL be sampled every wclk edge into a SYNC_STAGES-deep flop chain, and g_rptr_sync SHALL be the last stage, giving a latency of SYNC_STAGES edges.
REQ-016 No logic SHALL be placed between synchronizer stages, and g_rptr SHALL be used only through stage 1.
REQ-017 b_rptr_sync SHALL register the Gray-to-binary conversion of g_rptr_sync, so it trails g_rptr_sync by one edge.
REQ-018 wr_level SHALL register (b_wptr - b_rptr_sync) modulo 2**(PTRWIDTH+1), with one-edge latency from either operand.
REQ-019 Wrap-around SHALL be handled by modular subtraction only; the MSB difference with equal lower bits SHALL yield wr_level = DEPTH.
REQ-020 At wr_level = DEPTH, the outputs SHALL be wr_free = 0 and almost_full = 1.
REQ-021 At wr_level = 0, the outputs SHALL be wr_free = DEPTH and almost_full = 0.
REQ-022 wr_free and almost_full SHALL be registered in the same cycle as wr_level, so all three are mutually consistent in every cycle.
REQ-023 rptr_adv SHALL be 1 for exactly one cycle, in the cycle b_rptr_sync updates to a value different from its previous value.
REQ-024 Simultaneous changes of b_wptr and the synchronized read pointer SHALL both be reflected in the same wr_level update.

Reset
REQ-025 While wrst_n = 0, every flop SHALL clear asynchronously: synchronizer stages, g_rptr_sync, b_rptr_sync, wr_level, rptr_adv, almost_full and gray_err go to 0, and wr_free goes to DEPTH.
REQ-026 Reset asserted mid-operation SHALL override all activity immediately; after deassertion, outputs SHALL track inputs with normal latency, with no spurious rptr_adv on the first edge.

Configuration
REQ-027 With macro RPTR_WSYNC_GRAY_CHECK_EN defined, gray_err SHALL set on an edge where g_rptr_sync differs from its previous value in more than one bit, or where the computed level exceeds DEPTH.
REQ-028 With RPTR_WSYNC_GRAY_CHECK_EN defined, gray_err SHALL stay set until reset.
REQ-029 Without RPTR_WSYNC_GRAY_CHECK_EN, the gray_err port SHALL remain, tied to 0, with no checker logic.

Verification
REQ-030 Reset: with wrst_n=0 and g_rptr=4'b0110, all outputs SHALL be 0 and wr_free=8; after release, g_rptr_sync SHALL be 0110 at edge 2 and b_rptr_sync SHALL be 0100 at edge 3, with no rptr_adv pulse.
REQ-031 Latency: g_rptr stepping 0000->0001 SHALL give g_rptr_sync=0001 at edge 2, then b_rptr_sync=0001, wr_level decremented and a single rptr_adv pulse at edge 3.
REQ-032 Full: b_wptr=1000 with g_rptr=0000 SHALL give wr_level=8, wr_free=0 and almost_full=1.
REQ-033 Wrap: b_wptr=0010 with g_rptr=1001 (binary 14) SHALL give wr_level=4, wr_free=4 and almost_full=0.
REQ-034 Almost-full: b_wptr=0111 with g_rptr=0000 SHALL give wr_level=7, wr_free=1 and almost_full=1; b_wptr=0110 SHALL give almost_full=0.
REQ-035 Gray check: with the macro defined, g_rptr jumping 0000->0011 SHALL set gray_err=1, held until wrst_n pulses; without the macro, gray_err SHALL stay 0.

Source files
------------

// File: rtl/rptr_wsync.sv
// Carries the Gray read pointer into the write clock domain and derives the write-side level, free count and flags.
// Optional checker: define RPTR_WSYNC_GRAY_CHECK_EN to enable the sticky gray_err protocol check.
module rptr_wsync #(
    parameter int unsigned PTRWIDTH    = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 1
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [PTRWIDTH:0]   g_rptr,
    input  logic [PTRWIDTH:0]   b_wptr,
    output logic [PTRWIDTH:0]   g_rptr_sync,
    output logic [PTRWIDTH:0]   b_rptr_sync,
    output logic [PTRWIDTH:0]   wr_level,
    output logic [PTRWIDTH:0]   wr_free,
    output logic                almost_full,
    output logic                rptr_adv,
    output logic                gray_err
);

    localparam int unsigned PW    = PTRWIDTH + 1;
    localparam int unsigned DEPTH = 1 << PTRWIDTH;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [SYNC_STAGES:0]           fill_q;
    logic [PW-1:0]                  b_next;
    logic [PW-1:0]                  level_next;

    assign g_rptr_sync = sync_q[SYNC_STAGES-1];

    // Plain flop chain; g_rptr touches nothing but stage 1.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= g_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // fill_q[k] marks that stage k carries a real sample since reset; masks the reset-to-first-sample step.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        b_next     = gray2bin(g_rptr_sync);
        level_next = b_wptr - b_next;
    end

    // Level is taken from the same converted pointer that loads b_rptr_sync, so both update together.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_rptr_sync <= '0;
            wr_level    <= '0;
            wr_free     <= DEPTH_P;
            almost_full <= 1'b0;
            rptr_adv    <= 1'b0;
        end else begin
            b_rptr_sync <= b_next;
            wr_level    <= level_next;
            wr_free     <= DEPTH_P - level_next;
            almost_full <= (level_next >= AF_LEVEL);
            rptr_adv    <= fill_q[SYNC_STAGES] & (b_next != b_rptr_sync);
        end
    end

`ifdef RPTR_WSYNC_GRAY_CHECK_EN
    logic [PW-1:0] g_diff;
    logic          err_set;

    always_comb begin
        g_diff  = sync_q[SYNC_STAGES-2] ^ sync_q[SYNC_STAGES-1];
        err_set = fill_q[SYNC_STAGES-1]
                & ((|(g_diff & (g_diff - PW'(1)))) | (level_next > DEPTH_P));
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            gray_err <= 1'b0;
        end else begin
            gray_err <= gray_err | err_set;
        end
    end
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_wsync.sv
// Randomized bench for rptr_wsync with an edge-indexed reference model and literal anchor checks.
module tb_rptr_wsync;

    localparam int unsigned PTRWIDTH    = 3;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned AF_THRESH   = 1;
    localparam int unsigned PW          = PTRWIDTH + 1;
    localparam int unsigned DEPTH       = 1 << PTRWIDTH;

    logic          wclk   = 1'b0;
    logic          wrst_n = 1'b0;
    logic [PW-1:0] g_rptr = 4'b0110;
    logic [PW-1:0] b_wptr = 4'b0100;
    logic [PW-1:0] g_rptr_sync, b_rptr_sync, wr_level, wr_free;
    logic          almost_full, rptr_adv, gray_err;

`ifdef RPTR_WSYNC_GRAY_CHECK_EN
    localparam logic GCHK = 1'b1;
`else
    localparam logic GCHK = 1'b0;
`endif

    rptr_wsync #(
        .PTRWIDTH   (PTRWIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .AF_THRESH  (AF_THRESH)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .g_rptr     (g_rptr),
        .b_wptr     (b_wptr),
        .g_rptr_sync(g_rptr_sync),
        .b_rptr_sync(b_rptr_sync),
        .wr_level   (wr_level),
        .wr_free    (wr_free),
        .almost_full(almost_full),
        .rptr_adv   (rptr_adv),
        .gray_err   (gray_err)
    );

    always #5 wclk = ~wclk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int s = 1; s < int'(PW); s = s << 1) b = b ^ (b >> s);
        return b;
    endfunction

    // Reference model: edge n after reset release; synced value is the sample taken SYNC_STAGES-1 edges earlier.
    int            m_n = 0;
    logic [PW-1:0] m_hist[$];
    logic [PW-1:0] m_gs = '0, m_bs = '0, m_lvl = '0, m_free = PW'(DEPTH);
    logic          m_af = 1'b0, m_adv = 1'b0, m_err = 1'b0;

    always @(posedge wclk or negedge wrst_n) begin
        logic [PW-1:0] n_gs, n_bs, n_lvl;
        if (!wrst_n) begin
            m_n = 0; m_hist.delete();
            m_gs = '0; m_bs = '0; m_lvl = '0; m_free = PW'(DEPTH);
            m_af = 1'b0; m_adv = 1'b0; m_err = 1'b0;
        end else begin
            m_n++;
            m_hist.push_back(g_rptr);
            if (m_hist.size() > SYNC_STAGES) void'(m_hist.pop_front());
            n_gs  = (m_hist.size() == SYNC_STAGES) ? m_hist[0] : '0;
            n_bs  = to_bin(m_gs);
            n_lvl = PW'(b_wptr - n_bs);
            if (GCHK && m_n >= int'(SYNC_STAGES) + 1 &&
                ($countones(n_gs ^ m_gs) > 1 || int'(n_lvl) > int'(DEPTH)))
                m_err = 1'b1;
            m_adv  = (m_n >= int'(SYNC_STAGES) + 2) && (n_bs != m_bs);
            m_gs   = n_gs;
            m_bs   = n_bs;
            m_lvl  = n_lvl;
            m_free = PW'(DEPTH - int'(n_lvl));
            m_af   = int'(n_lvl) >= int'(DEPTH - AF_THRESH);
        end
    end

    always @(negedge wclk) begin
        check("g_rptr_sync", 32'(g_rptr_sync), 32'(m_gs));
        check("b_rptr_sync", 32'(b_rptr_sync), 32'(m_bs));
        check("wr_level",    32'(wr_level),    32'(m_lvl));
        check("wr_free",     32'(wr_free),     32'(m_free));
        check("almost_full", 32'(almost_full), 32'(m_af));
        check("rptr_adv",    32'(rptr_adv),    32'(m_adv));
        check("gray_err",    32'(gray_err),    32'(m_err));
    end

    task automatic edges(input int k);
        repeat (k) @(posedge wclk);
        #2;
    endtask

    task automatic reset_pulse(input logic [PW-1:0] g, input logic [PW-1:0] w, input int settle);
        wrst_n = 1'b0;
        #1;
        check("rst_level", 32'(wr_level), 32'd0);
        check("rst_free",  32'(wr_free),  32'(DEPTH));
        check("rst_gsync", 32'(g_rptr_sync), 32'd0);
        check("rst_err",   32'(gray_err), 32'd0);
        g_rptr = g;
        b_wptr = w;
        edges(1);
        wrst_n = 1'b1;
        edges(settle);
    endtask

    logic [PW-1:0] rb, wb, old;
    logic [PW-1:0] rb_hist[$];

    initial begin
        // Reset with g_rptr=0110 applied, then release.
        edges(3);
        check("r_gsync", 32'(g_rptr_sync), 32'd0);
        check("r_bsync", 32'(b_rptr_sync), 32'd0);
        check("r_level", 32'(wr_level), 32'd0);
        check("r_free",  32'(wr_free), 32'd8);
        check("r_af",    32'(almost_full), 32'd0);
        check("r_adv",   32'(rptr_adv), 32'd0);
        wrst_n = 1'b1;
        edges(2);
        check("r_gsync_e2", 32'(g_rptr_sync), 32'b0110);
        edges(1);
        check("r_bsync_e3", 32'(b_rptr_sync), 32'b0100);
        check("r_adv_e3",   32'(rptr_adv), 32'd0);

        // Latency of a single read-pointer step.
        reset_pulse(4'b0000, 4'b0011, 6);
        g_rptr = 4'b0001;
        edges(2);
        check("l_gsync_e2", 32'(g_rptr_sync), 32'b0001);
        check("l_adv_e2",   32'(rptr_adv), 32'd0);
        edges(1);
        check("l_bsync_e3", 32'(b_rptr_sync), 32'b0001);
        check("l_level_e3", 32'(wr_level), 32'd2);
        check("l_adv_e3",   32'(rptr_adv), 32'd1);
        edges(1);
        check("l_adv_e4",   32'(rptr_adv), 32'd0);

        // Full.
        reset_pulse(4'b0000, 4'b1000, 5);
        check("f_level", 32'(wr_level), 32'd8);
        check("f_free",  32'(wr_free), 32'd0);
        check("f_af",    32'(almost_full), 32'd1);

        // Wrap: 2 - 14 mod 16.
        reset_pulse(4'b1001, 4'b0010, 5);
        check("w_level", 32'(wr_level), 32'd4);
        check("w_free",  32'(wr_free), 32'd4);
        check("w_af",    32'(almost_full), 32'd0);

        // Almost-full boundary.
        reset_pulse(4'b0000, 4'b0111, 5);
        check("a_level", 32'(wr_level), 32'd7);
        check("a_free",  32'(wr_free), 32'd1);
        check("a_af",    32'(almost_full), 32'd1);
        b_wptr = 4'b0110;
        edges(1);
        check("a_af_6",    32'(almost_full), 32'd0);
        check("a_level_6", 32'(wr_level), 32'd6);

        // Two-bit Gray jump.
        reset_pulse(4'b0000, 4'b0011, 5);
        g_rptr = 4'b0011;
        edges(3);
        check("g_err_set",  32'(gray_err), 32'(GCHK));
        edges(4);
        check("g_err_hold", 32'(gray_err), 32'(GCHK));
        reset_pulse(4'b0011, 4'b0011, 3);
        check("g_err_clr",  32'(gray_err), 32'd0);

        // Randomized legal traffic with one mid-run reset.
        reset_pulse(4'b0000, 4'b0000, 4);
        rb = '0;
        wb = '0;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                rb = '0;
                wb = '0;
                rb_hist.delete();
                reset_pulse(4'b0000, 4'b0000, 1);
            end
            rb_hist.push_back(rb);
            if (rb_hist.size() > 6) void'(rb_hist.pop_front());
            old = rb_hist[0];
            if ($urandom_range(0, 1) == 1 && int'(PW'(wb - old)) < int'(DEPTH)) wb = wb + 1'b1;
            if ($urandom_range(0, 2) != 0 && rb != wb) rb = rb + 1'b1;
            g_rptr = rb ^ (rb >> 1);
            b_wptr = wb;
            edges(1);
        end
        edges(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
